// File: rtl/sha1_pio_pkg.sv
// Shared definitions for the pushbutton PIO initiator: PIO register map,
// FSM state encoding and the lockout counter width helper.
// No ports; imported by the initiator, its lockout timer and the bench.
package sha1_pio_pkg;

  // Word addresses of the pushbutton PIO registers
  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    RD_ADR,
    RD_DAT,
    CLR,
    EMIT
  } state_t;

  // Counter width able to hold n, never narrower than one bit
  function automatic int unsigned lockout_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sha1_pushbutton_irq_master_if.sv
// Bundle between the pushbutton initiator and its environment: the Avalon-MM
// link to the PIO (address/chipselect/write_n/writedata/readdata, plus irq)
// and the button event stream (valid/buttons/ready, running event count).
// master = initiator side, slave = PIO + event consumer side.
interface sha1_pushbutton_irq_master_if #(
  parameter int unsigned WIDTH = 2
);
  logic             irq;
  logic [1:0]       avm_address;
  logic             avm_chipselect;
  logic             avm_write_n;
  logic [31:0]      avm_writedata;
  logic [31:0]      avm_readdata;
  logic             evt_valid;
  logic [WIDTH-1:0] evt_buttons;
  logic             evt_ready;
  logic [15:0]      evt_count;

  modport master (
    input  irq, avm_readdata, evt_ready,
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
           evt_valid, evt_buttons, evt_count
  );

  modport slave (
    output irq, avm_readdata, evt_ready,
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
           evt_valid, evt_buttons, evt_count
  );
endinterface

// File: rtl/sha1_lockout_timer.sv
// Purpose: loadable down-counter that saturates at zero; o_zero flags expiry.
// Latency: load takes effect on the next clock edge; o_zero is decoded from the counter register.
// Backpressure: none. Ports: clk, reset_n (async low), i_load, o_zero.
module sha1_lockout_timer
  import sha1_pio_pkg::*;
#(
  parameter int unsigned LOCKOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  output logic o_zero
);

  localparam int unsigned W = lockout_width(LOCKOUT_CYCLES);
  localparam logic [W-1:0] LOAD_VAL = W'(LOCKOUT_CYCLES);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sha1_pushbutton_irq_master.sv
// Purpose: Avalon-MM initiator servicing the pushbutton PIO irq and streaming button events.
// Latency: irq seen in IDLE -> edge_capture clear write after 3 cycles -> evt_valid after 4 cycles.
// Backpressure: event held stable in EMIT until evt_ready; new irqs wait (pending in the PIO).
// Ports: clk, reset_n (async low), bus (master modport: PIO bus + irq + event stream + count).
module sha1_pushbutton_irq_master
  import sha1_pio_pkg::*;
#(
  parameter int unsigned     WIDTH          = 2,
  parameter logic [WIDTH-1:0] MASK_INIT     = 2'b11,
  parameter int unsigned     LOCKOUT_CYCLES = 16
) (
  input logic clk,
  input logic reset_n,
  sha1_pushbutton_irq_master_if.master bus
);

  state_t           r_state;
  logic [1:0]       r_addr;
  logic             r_cs;
  logic             r_wr_n;
  logic [31:0]      r_wdata;
  logic             r_vld;
  logic [WIDTH-1:0] r_btn;
  logic [15:0]      r_cnt;
  logic [WIDTH-1:0] r_cap;

  state_t           w_state_nxt;
  logic [1:0]       w_addr_nxt;
  logic             w_cs_nxt;
  logic             w_wr_n_nxt;
  logic [31:0]      w_wdata_nxt;
  logic             w_vld_nxt;
  logic [WIDTH-1:0] w_btn_nxt;
  logic [15:0]      w_cnt_nxt;
  logic [WIDTH-1:0] w_cap_nxt;
  logic             w_load;
  logic             w_lockout_zero;
  logic [WIDTH-1:0] w_rd_cap;
  logic             w_unused_rd_hi;

  // Only the button bits of edge_capture matter; the rest of the word is ignored.
  assign w_rd_cap       = bus.avm_readdata[WIDTH-1:0];
  assign w_unused_rd_hi = ^bus.avm_readdata[31:WIDTH];

  sha1_lockout_timer #(
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) u_lockout (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .o_zero  (w_lockout_zero)
  );

  // Bus and event outputs are registered, so each state computes the values
  // that the *next* state presents. ARM is entered straight from reset with
  // idle outputs, so it spends one cycle launching the mask write and a second
  // cycle with that write on the bus before moving to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cs_nxt    = 1'b0;
    w_wr_n_nxt  = 1'b1;
    w_wdata_nxt = '0;
    w_vld_nxt   = r_vld;
    w_btn_nxt   = r_btn;
    w_cnt_nxt   = r_cnt;
    w_cap_nxt   = r_cap;
    w_load      = 1'b0;

    case (r_state)
      ARM: begin
        if (!r_cs) begin
          w_cs_nxt                 = 1'b1;
          w_wr_n_nxt               = 1'b0;
          w_addr_nxt               = PIO_ADDR_IRQMASK;
          w_wdata_nxt[WIDTH-1:0]   = MASK_INIT;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      IDLE: begin
        if (bus.irq && w_lockout_zero) begin
          w_state_nxt = RD_ADR;
          w_addr_nxt  = PIO_ADDR_EDGECAP;
          w_cs_nxt    = 1'b1;
        end
      end

      RD_ADR: begin
        // PIO readdata is registered: the value shows up while in RD_DAT.
        w_state_nxt = RD_DAT;
        w_addr_nxt  = PIO_ADDR_EDGECAP;
      end

      RD_DAT: begin
        w_cap_nxt = w_rd_cap;
        if (w_rd_cap == '0) begin
          // Spurious irq: nothing captured, nothing to clear or report.
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt             = CLR;
          w_cs_nxt                = 1'b1;
          w_wr_n_nxt              = 1'b0;
          w_addr_nxt              = PIO_ADDR_EDGECAP;
          // Write-1-to-clear only the bits that were read, so later edges survive.
          w_wdata_nxt[WIDTH-1:0]  = w_rd_cap;
        end
      end

      CLR: begin
        w_load      = 1'b1;
        w_state_nxt = EMIT;
        w_vld_nxt   = 1'b1;
        w_btn_nxt   = r_cap;
      end

      EMIT: begin
        if (bus.evt_ready) begin
          w_state_nxt = IDLE;
          w_vld_nxt   = 1'b0;
          w_cnt_nxt   = r_cnt + 16'd1;
        end
      end

      default: begin
        w_state_nxt = ARM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ARM;
      r_addr  <= '0;
      r_cs    <= 1'b0;
      r_wr_n  <= 1'b1;
      r_wdata <= '0;
      r_vld   <= 1'b0;
      r_btn   <= '0;
      r_cnt   <= '0;
      r_cap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_cs    <= w_cs_nxt;
      r_wr_n  <= w_wr_n_nxt;
      r_wdata <= w_wdata_nxt;
      r_vld   <= w_vld_nxt;
      r_btn   <= w_btn_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cap   <= w_cap_nxt;
    end
  end

  assign bus.avm_address    = r_addr;
  assign bus.avm_chipselect = r_cs;
  assign bus.avm_write_n    = r_wr_n;
  assign bus.avm_writedata  = r_wdata;
  assign bus.evt_valid      = r_vld;
  assign bus.evt_buttons    = r_btn;
  assign bus.evt_count      = r_cnt;

endmodule

// File: tb/tb_sha1_pushbutton_irq_master.sv
`timescale 1ns/1ps
module tb_sha1_pushbutton_irq_master;
  import sha1_pio_pkg::*;

  localparam int unsigned WIDTH   = 2;
  localparam int          LOCKOUT = 16;
  localparam logic [1:0]  MASK    = 2'b11;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sha1_pushbutton_irq_master_if #(.WIDTH(WIDTH)) bus ();

  sha1_pushbutton_irq_master #(
    .WIDTH(WIDTH), .MASK_INIT(MASK), .LOCKOUT_CYCLES(LOCKOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural pushbutton PIO ----------------
  logic [1:0]  in_port   = 2'b11;
  logic        force_irq = 1'b0;
  logic        evt_rdy   = 1'b0;
  logic [1:0]  pio_prev, pio_ec, pio_mask, pio_clr;
  logic [31:0] pio_rd, pio_rnd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_prev <= in_port;
      pio_ec   <= 2'b00;
      pio_mask <= 2'b00;
      pio_rd   <= 32'h0;
    end else begin
      pio_clr = (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd3)
                ? bus.avm_writedata[1:0] : 2'b00;
      pio_rnd = $urandom;
      pio_prev <= in_port;
      // a press is a falling edge; clears only remove the written bits
      pio_ec <= (pio_ec & ~pio_clr) | (pio_prev & ~in_port);
      if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd2)
        pio_mask <= bus.avm_writedata[1:0];
      // upper readdata bits carry garbage the initiator must ignore
      case (bus.avm_address)
        2'd0:    pio_rd <= {pio_rnd[31:2], in_port};
        2'd2:    pio_rd <= {pio_rnd[31:2], pio_mask};
        2'd3:    pio_rd <= {pio_rnd[31:2], pio_ec};
        default: pio_rd <= pio_rnd;
      endcase
    end
  end

  assign bus.irq          = (|(pio_ec & pio_mask)) | force_irq;
  assign bus.avm_readdata = pio_rd;
  assign bus.evt_ready    = evt_rdy;

  // ---------------- transaction-level checker ----------------
  int         model_cnt = 0;
  logic       expect_arm = 1'b1;
  logic [1:0] last_cap = 2'b00;
  logic [31:0] last_wdata = 32'h0;
  logic       rd_pend = 1'b0, clr_due = 1'b0, evt_due = 1'b0;
  logic       prev_hold = 1'b0, prev_valid = 1'b0;
  logic [1:0] prev_btn = 2'b00;
  int         rd_cyc = 0, wr_cyc = 0, clr_cyc = -1000;
  int         n_arm = 0, n_rd = 0, n_clr = 0, n_evt = 0;
  logic [1:0] evq[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      model_cnt = 0; expect_arm = 1'b1; rd_pend = 1'b0; clr_due = 1'b0;
      evt_due = 1'b0; prev_hold = 1'b0; prev_valid = 1'b0; clr_cyc = -1000;
    end else begin
      check("evt_count", {16'h0, bus.evt_count}, model_cnt[15:0]);
      check("wdata_upper", {2'b00, bus.avm_writedata[31:2]}, 32'h0);
      if (rd_pend) begin
        last_cap = bus.avm_readdata[1:0];
        rd_pend  = 1'b0;
        clr_due  = (last_cap != 2'b00);
      end
      if (clr_due && cyc - rd_cyc > 2) begin
        check("clr_missing", clr_due, 1'b0);
        clr_due = 1'b0;
      end
      if (bus.avm_chipselect && bus.avm_write_n) begin
        check("rd_addr", bus.avm_address, 2'd3);
        check("rd_after_lockout", (cyc - clr_cyc) > LOCKOUT, 1'b1);
        check("rd_while_busy", {clr_due, evt_due}, 2'b00);
        rd_pend = 1'b1; rd_cyc = cyc; n_rd++;
      end
      if (bus.avm_chipselect && !bus.avm_write_n) begin
        if (bus.avm_address == 2'd2) begin
          check("arm_expected", expect_arm, 1'b1);
          check("arm_wdata", bus.avm_writedata, {30'h0, MASK});
          expect_arm = 1'b0; n_arm++;
        end else begin
          check("clr_addr", bus.avm_address, 2'd3);
          check("clr_expected", clr_due, 1'b1);
          check("clr_wdata", bus.avm_writedata, {30'h0, last_cap});
          check("clr_latency", cyc - rd_cyc, 2);
          last_wdata = bus.avm_writedata;
          clr_due = 1'b0; evt_due = 1'b1; clr_cyc = cyc; wr_cyc = cyc; n_clr++;
        end
      end
      if (prev_hold) begin
        check("hold_valid", bus.evt_valid, 1'b1);
        check("hold_buttons", bus.evt_buttons, prev_btn);
      end
      if (evt_due && !bus.evt_valid && cyc - wr_cyc >= 1) begin
        check("evt_late", bus.evt_valid, 1'b1);
        evt_due = 1'b0;
      end
      if (bus.evt_valid) begin
        check("evt_expected", evt_due, 1'b1);
        check("evt_buttons", bus.evt_buttons, last_cap);
        if (!prev_valid) check("evt_latency", cyc - wr_cyc, 1);
        if (bus.evt_ready) begin
          model_cnt++; evt_due = 1'b0; n_evt++;
          evq.push_back(bus.evt_buttons);
        end
      end
      prev_hold  = bus.evt_valid && !bus.evt_ready;
      prev_btn   = bus.evt_buttons;
      prev_valid = bus.evt_valid;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int t_irq, t_v, n0, n_clr0, n_evt0, n_arm0;
    logic found;

    step(3);
    check("rst_cs",      bus.avm_chipselect, 1'b0);
    check("rst_write_n", bus.avm_write_n,    1'b1);
    check("rst_addr",    bus.avm_address,    2'd0);
    check("rst_wdata",   bus.avm_writedata,  32'h0);
    check("rst_valid",   bus.evt_valid,      1'b0);
    check("rst_buttons", bus.evt_buttons,    2'b00);
    check("rst_count",   bus.evt_count,      16'h0);

    // 1: single mask write after release
    reset_n = 1'b1;
    for (int k = 0; k < 10 && n_arm == 0; k++) step(1);
    step(5);
    check("arm_once", n_arm, 1);
    check("idle_cs", bus.avm_chipselect, 1'b0);
    check("mask_written", pio_mask, 2'b11);

    // 2 + 3: press btn0, hold off the consumer for 10 cycles
    step(20);
    in_port = 2'b10;
    t_irq = -1;
    for (int k = 0; k < 10 && t_irq < 0; k++) begin
      step(1);
      if (bus.irq) t_irq = cyc;
    end
    t_v = -1;
    for (int k = 0; k < 20 && t_v < 0; k++) begin
      if (bus.evt_valid) t_v = cyc; else step(1);
    end
    check("btn0_valid_latency", t_v - t_irq, 4);
    check("btn0_read", last_cap, 2'b01);
    check("btn0_clr_wdata", last_wdata, 32'h1);
    check("btn0_buttons", bus.evt_buttons, 2'b01);
    step(10);
    check("held_valid", bus.evt_valid, 1'b1);
    check("held_count", bus.evt_count, 16'd0);
    in_port = 2'b11;
    evt_rdy = 1'b1;
    step(1);
    check("hs_valid_drop", bus.evt_valid, 1'b0);
    check("hs_count", bus.evt_count, 16'd1);
    step(3);
    check("hs_count_once", bus.evt_count, 16'd1);

    // 4: btn1 pressed two cycles after the btn0 read
    step(30);
    evq.delete();
    n0 = n_rd;
    in_port = 2'b10;
    for (int k = 0; k < 20 && n_rd == n0; k++) step(1);
    step(1);
    in_port = 2'b00;
    for (int k = 0; k < 80 && evq.size() < 2; k++) step(1);
    check("two_events", evq.size(), 2);
    if (evq.size() >= 2) begin
      check("first_event", evq[0], 2'b01);
      check("second_event", evq[1], 2'b10);
    end
    in_port = 2'b11;
    step(30);

    // 5: spurious irq
    n0 = n_rd; n_clr0 = n_clr; n_evt0 = n_evt;
    force_irq = 1'b1;
    for (int k = 0; k < 20 && n_rd == n0; k++) step(1);
    force_irq = 1'b0;
    step(10);
    check("spur_reads", n_rd - n0, 1);
    check("spur_read_val", last_cap, 2'b00);
    check("spur_no_clear", n_clr - n_clr0, 0);
    check("spur_no_event", n_evt - n_evt0, 0);
    check("spur_idle_cs", bus.avm_chipselect, 1'b0);
    check("spur_idle_valid", bus.evt_valid, 1'b0);

    // random presses and consumer stalls
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) in_port = in_port ^ 2'($urandom_range(0, 3));
      evt_rdy = ($urandom_range(0, 3) != 0);
      step(1);
    end
    in_port = 2'b11;
    evt_rdy = 1'b1;
    step(100);
    check("drain_edgecap", pio_ec, 2'b00);
    check("drain_irq", bus.irq, 1'b0);
    check("drain_valid", bus.evt_valid, 1'b0);
    check("drain_count", bus.evt_count, n_evt[15:0]);

    // 6: reset in the middle of the clear write
    in_port = 2'b10;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk); #1;
      found = bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd3;
    end
    check("clr_reached", found, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_cs",      bus.avm_chipselect, 1'b0);
    check("mid_rst_write_n", bus.avm_write_n,    1'b1);
    check("mid_rst_addr",    bus.avm_address,    2'd0);
    check("mid_rst_wdata",   bus.avm_writedata,  32'h0);
    check("mid_rst_valid",   bus.evt_valid,      1'b0);
    check("mid_rst_buttons", bus.evt_buttons,    2'b00);
    check("mid_rst_count",   bus.evt_count,      16'h0);
    in_port = 2'b11;
    step(3);
    n_arm0 = n_arm;
    reset_n = 1'b1;
    for (int k = 0; k < 10 && n_arm == n_arm0; k++) step(1);
    step(3);
    check("rearm_once", n_arm - n_arm0, 1);
    check("rearm_count", bus.evt_count, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
